// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the shared RAM and the arbiter.
// The arbiter uses the slave view; the surrounding logic (or a bench) uses the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and the memory stage (load/store).
// One transaction in flight; data has priority, capped by a fairness streak; a watchdog
// ends hung transactions with an error response.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// ISSUE | mem_req held with the latched payload until mem_ready
// WAIT  | request accepted, waiting for mem_rvalid
// RESP  | owner's rvalid pulse with rdata/err, then back to IDLE
module mem_port_arbiter #(
  parameter int FAIR_LIMIT  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, next_state;
  logic          owner_fetch, owner_fetch_next;
  logic          kill, kill_next;
  logic [SW-1:0] streak, streak_next;
  logic [TW-1:0] tmo_cnt, tmo_next;
  logic          pay_we, pay_we_next;
  logic [3:0]    pay_be, pay_be_next;
  logic [31:0]   pay_addr, pay_addr_next;
  logic [31:0]   pay_wdata, pay_wdata_next;

  logic          if_gnt_next, if_rvalid_next, if_err_next;
  logic [31:0]   if_rdata_next;
  logic          dm_gnt_next, dm_rvalid_next, dm_err_next;
  logic [31:0]   dm_rdata_next;
  logic          mem_req_next, mem_we_next;
  logic [3:0]    mem_be_next;
  logic [31:0]   mem_addr_next, mem_wdata_next;
  logic          busy_next;
  logic [31:0]   resp_data;

  // Transaction events; the timer is a down-counter that expires at zero.
  logic start, pick_fetch, in_xact, handshake, done, tmo, to_resp;
  assign start      = (state == IDLE) && (bus.if_req || bus.dm_req);
  assign pick_fetch = bus.if_req && (!bus.dm_req || streak == SW'(FAIR_LIMIT));
  assign in_xact    = (state == ISSUE) || (state == WAIT);
  assign handshake  = (state == ISSUE) && bus.mem_ready;
  assign done       = ((state == ISSUE) && bus.mem_ready && bus.mem_rvalid) ||
                      ((state == WAIT) && bus.mem_rvalid);
  assign tmo        = in_xact && !handshake && !done && (tmo_cnt == '0);
  assign to_resp    = done || tmo;

  // State register plus all registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner_fetch   <= 1'b0;
      kill          <= 1'b0;
      streak        <= '0;
      tmo_cnt       <= '0;
      pay_we        <= 1'b0;
      pay_be        <= '0;
      pay_addr      <= '0;
      pay_wdata     <= '0;
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.if_err    <= 1'b0;
      bus.dm_gnt    <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.dm_rdata  <= '0;
      bus.dm_err    <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      owner_fetch   <= owner_fetch_next;
      kill          <= kill_next;
      streak        <= streak_next;
      tmo_cnt       <= tmo_next;
      pay_we        <= pay_we_next;
      pay_be        <= pay_be_next;
      pay_addr      <= pay_addr_next;
      pay_wdata     <= pay_wdata_next;
      bus.if_gnt    <= if_gnt_next;
      bus.if_rvalid <= if_rvalid_next;
      bus.if_rdata  <= if_rdata_next;
      bus.if_err    <= if_err_next;
      bus.dm_gnt    <= dm_gnt_next;
      bus.dm_rvalid <= dm_rvalid_next;
      bus.dm_rdata  <= dm_rdata_next;
      bus.dm_err    <= dm_err_next;
      bus.mem_req   <= mem_req_next;
      bus.mem_we    <= mem_we_next;
      bus.mem_be    <= mem_be_next;
      bus.mem_addr  <= mem_addr_next;
      bus.mem_wdata <= mem_wdata_next;
      busy          <= busy_next;
    end
  end

  // Next-state decision.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ISSUE;
      ISSUE:   if (to_resp) next_state = RESP;
               else if (bus.mem_ready) next_state = WAIT;
      WAIT:    if (to_resp) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values for datapath and registered outputs.
  always_comb begin
    owner_fetch_next = owner_fetch;
    pay_we_next      = pay_we;
    pay_be_next      = pay_be;
    pay_addr_next    = pay_addr;
    pay_wdata_next   = pay_wdata;
    streak_next      = streak;
    tmo_next         = tmo_cnt;
    kill_next        = kill;

    if (start) begin
      owner_fetch_next = pick_fetch;
      if (pick_fetch) begin
        pay_we_next    = 1'b0;
        pay_be_next    = 4'hF;
        pay_addr_next  = bus.if_addr;
        pay_wdata_next = '0;
      end else begin
        pay_we_next    = bus.dm_we;
        pay_be_next    = bus.dm_be;
        pay_addr_next  = bus.dm_addr;
        pay_wdata_next = bus.dm_wdata;
      end
      streak_next = (pick_fetch || !bus.if_req) ? '0 : streak + SW'(1);
    end

    // A flushed fetch still finishes on the memory side; only its response is hidden.
    if (state == IDLE) kill_next = 1'b0;
    else if (owner_fetch && bus.if_kill) kill_next = 1'b1;

    if (start || handshake) tmo_next = TMO_LOAD;
    else if (in_xact && tmo_cnt != '0) tmo_next = tmo_cnt - TW'(1);

    resp_data = (done && !pay_we) ? bus.mem_rdata : '0;

    if_gnt_next    = start && pick_fetch;
    dm_gnt_next    = start && !pick_fetch;
    mem_req_next   = (next_state == ISSUE);
    mem_we_next    = mem_req_next && pay_we_next;
    mem_be_next    = mem_req_next ? pay_be_next : '0;
    mem_addr_next  = mem_req_next ? pay_addr_next : '0;
    mem_wdata_next = mem_req_next ? pay_wdata_next : '0;
    if_rvalid_next = to_resp && owner_fetch && !kill_next;
    if_err_next    = if_rvalid_next && tmo;
    if_rdata_next  = if_rvalid_next ? resp_data : '0;
    dm_rvalid_next = to_resp && !owner_fetch;
    dm_err_next    = dm_rvalid_next && tmo;
    dm_rdata_next  = dm_rvalid_next ? resp_data : '0;
    busy_next      = (next_state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of single transactions plus hand-written
// sequences for fairness, flush, and reset. Responses are checked through a scoreboard.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.FAIR_LIMIT(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  typedef struct {
    bit fetch; bit we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] mrdata; int rdy_wait; int rv_wait; bit hang;
    logic [31:0] exp_rdata; bit exp_err; int exp_lat; int exp_mreq;
  } vec_t;
  typedef struct { bit fetch; logic [31:0] rdata; bit err; } resp_t;

  resp_t sb[$];
  vec_t  vecs[8];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit f, bit we, logic [3:0] be, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] mr, int rdy, int rv, bit hang, logic [31:0] er,
                              bit ee, int lat, int mreq);
    vec_t v;
    v.fetch = f; v.we = we; v.be = be; v.addr = a; v.wdata = wd; v.mrdata = mr;
    v.rdy_wait = rdy; v.rv_wait = rv; v.hang = hang; v.exp_rdata = er; v.exp_err = ee;
    v.exp_lat = lat; v.exp_mreq = mreq;
    return v;
  endfunction

  function automatic logic [159:0] all_outs();
    return {busy, bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
            bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata, bus.dm_err,
            bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
  endfunction

  // Scoreboard: every rvalid pulse must match the oldest expected response.
  always @(negedge clk) begin
    resp_t e;
    if (bus.if_rvalid || bus.dm_rvalid) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected: if_rvalid=%0b dm_rvalid=%0b, expected no response",
                 bus.if_rvalid, bus.dm_rvalid);
      end else begin
        e = sb.pop_front();
        check("sb_port", {bus.if_rvalid, bus.dm_rvalid}, e.fetch ? 2'b10 : 2'b01);
        check("sb_rdata", e.fetch ? bus.if_rdata : bus.dm_rdata, e.rdata);
        check("sb_err", e.fetch ? bus.if_err : bus.dm_err, e.err);
      end
    end
  end

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.if_gnt || bus.dm_gnt;
    end
    check("gnt_seen", got, 1'b1);
  endtask

  // k counts negedges from the grant (first ISSUE cycle is k=0); mem inputs driven at
  // negedge k are sampled at the end of cycle k.
  task automatic run_xact(input vec_t v);
    bit got;
    int mreq_cnt = 0, rv_cnt = 0, rv_k = -1;
    logic [69:0] exp_pay;
    if (v.fetch) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end else begin
      bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_be = v.be;
      bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
    end
    sb.push_back('{fetch: v.fetch, rdata: v.exp_rdata, err: v.exp_err});
    wait_gnt(got);
    if (!got) begin
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      void'(sb.pop_back());
      return;
    end
    check("gnt_owner", {bus.if_gnt, bus.dm_gnt}, v.fetch ? 2'b10 : 2'b01);
    exp_pay = v.fetch ? {1'b1, 1'b0, 4'hF, v.addr, 32'h0}
                      : {1'b1, v.we, v.be, v.addr, v.wdata};
    check("issue_payload", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
          exp_pay);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.mem_req) mreq_cnt++;
      if (v.fetch ? bus.if_rvalid : bus.dm_rvalid) begin rv_cnt++; rv_k = k; end
      bus.mem_ready  = !v.hang && (k == v.rdy_wait);
      bus.mem_rvalid = !v.hang && (k == v.rdy_wait + v.rv_wait);
      bus.mem_rdata  = v.mrdata;
    end
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    check("mem_req_cycles", mreq_cnt, v.exp_mreq);
    check("rvalid_count", rv_cnt, 1);
    check("rvalid_latency", rv_k, v.exp_lat);
    check("idle_after", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int prev_cyc;
    bit exp_f[10];
    int if_seen;

    // fields: fetch we be addr wdata mem_rdata rdy rv hang | exp_rdata exp_err lat(from gnt) mreq
    vecs[0] = mk(0, 0, 4'hF, 32'h40, 32'h0,    32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 0, 2, 1);
    vecs[1] = mk(0, 1, 4'h3, 32'h80, 32'h1234, 32'hFFFFFFFF, 0, 1, 0, 32'h0,        0, 2, 1);
    vecs[2] = mk(1, 0, 4'h0, 32'h100, 32'hAAAA, 32'h13,      2, 0, 0, 32'h13,       0, 3, 3);
    vecs[3] = mk(0, 0, 4'hF, 32'h44, 32'h0,    32'hCAFE,     0, 0, 1, 32'h0,        1, 8, 8);
    vecs[4] = mk(1, 0, 4'h0, 32'h104, 32'h0,   32'hBEEF,     0, 0, 1, 32'h0,        1, 8, 8);
    vecs[5] = mk(0, 0, 4'hC, 32'h48, 32'h0,    32'h600DF00D, 7, 3, 0, 32'h600DF00D, 0, 11, 8);
    vecs[6] = mk(0, 0, 4'hF, 32'h4C, 32'h0,    32'h11112222, 0, 8, 0, 32'h11112222, 0, 9, 1);
    vecs[7] = mk(0, 0, 4'hF, 32'h50, 32'h0,    32'h33334444, 0, 9, 0, 32'h0,        1, 9, 1);

    bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", all_outs(), '0);

    for (int i = 0; i < 8; i++) run_xact(vecs[i]);

    // Fairness: both requests held, immediate memory; 4 data grants then 1 fetch.
    exp_f = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h300;
    prev_cyc = 0;
    for (int g = 0; g < 10; g++) begin
      wait_gnt(got);
      if (!got) break;
      check("fair_order", {bus.if_gnt, bus.dm_gnt}, exp_f[g] ? 2'b10 : 2'b01);
      check("fair_addr", bus.mem_addr, exp_f[g] ? 32'h200 : 32'h300);
      if (g > 0) check("fair_spacing", cyc - prev_cyc, 4);
      prev_cyc = cyc;
      sb.push_back('{fetch: exp_f[g], rdata: 32'hA000_0000 + g, err: 1'b0});
      if (g == 9) begin bus.if_req = 0; bus.dm_req = 0; end
      bus.mem_ready = 1;
      @(negedge clk);
      bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'hA000_0000 + g;
      @(negedge clk);
      bus.mem_rvalid = 0; bus.mem_rdata = 0;
    end
    bus.if_req = 0; bus.dm_req = 0;
    repeat (3) @(negedge clk);

    // Flush: fetch killed in WAIT gives no if_rvalid; the pending load proceeds normally.
    bus.if_req = 1; bus.if_addr = 32'h200;
    wait_gnt(got);
    check("kill_fetch_gnt", bus.if_gnt, 1'b1);
    bus.if_req = 0;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h300;
    sb.push_back('{fetch: 1'b0, rdata: 32'h77, err: 1'b0});
    bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0; bus.if_kill = 1;
    @(negedge clk);
    bus.if_kill = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    if_seen = bus.if_rvalid ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.if_rvalid) if_seen++;
      got = bus.dm_gnt;
    end
    check("kill_no_if_rvalid", if_seen, 0);
    check("kill_dm_gnt", got, 1'b1);
    bus.dm_req = 0; bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h77;
    @(negedge clk);
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(negedge clk);
    run_xact(mk(1, 0, 4'h0, 32'h208, 32'h0, 32'h1357, 0, 1, 0, 32'h1357, 0, 2, 1));

    // Reset in WAIT: transaction dropped, the late mem_rvalid ignored.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_be = 4'hF; bus.dm_addr = 32'h400;
    wait_gnt(got);
    bus.dm_req = 0; bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0; reset = 1;
    @(negedge clk);
    check("reset_mid_outputs", all_outs(), '0);
    reset = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h99;
    @(negedge clk);
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    check("reset_late_rvalid", all_outs(), '0);
    repeat (4) @(negedge clk);
    check("reset_stays_idle", all_outs(), '0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
